// File: rtl/comps_seq_pkg.sv
// Shared types for the comps comparator scheduler: FSM encoding,
// comparator input/output bundles and their widths.
package comps_seq_pkg;

  localparam int CMP_IN_W  = 5;
  localparam int CMP_OUT_W = 3;

  // State encodings kept as plain constants so older code can match on them
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRIVE = 2'd1;
  localparam logic [1:0] ST_RESP  = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    DRIVE = ST_DRIVE,
    RESP  = ST_RESP
  } state_t;

  // Field order matches the per-requester data slice {a,b1,b2,c1,c2}
  typedef struct packed {
    logic a;
    logic b1;
    logic b2;
    logic c1;
    logic c2;
  } cmp_in_t;

  // Field order matches the response word {w,x,y}
  typedef struct packed {
    logic w;
    logic x;
    logic y;
  } cmp_out_t;

endpackage

// File: rtl/comps_rr_arb.sv
// Combinational round-robin picker: the first set request found when
// searching upward from ptr+1 (wrapping) wins. The pointer register is
// owned by the caller.
module comps_rr_arb #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  grant_idx,
  output logic             any_valid
);

  // Requests rotated so that bit 0 is the requester right after ptr
  logic [N_REQ-1:0] rot_req;
  int               first_off;

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_rot
      assign rot_req[gi] = req[ID_W'((int'(ptr) + 1 + gi) % N_REQ)];
    end
  endgenerate

  // Lowest set bit of the rotated vector is the winner's distance from ptr+1
  always_comb begin
    first_off = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (rot_req[k]) first_off = k;
    end
  end

  assign any_valid = |req;
  assign grant_idx = ID_W'((int'(ptr) + 1 + first_off) % N_REQ);

  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_oh
      assign grant[gi] = any_valid && (grant_idx == ID_W'(gi));
    end
  endgenerate

endmodule

// File: rtl/comps_seq.sv
// Scheduler sharing one comps comparator among N_REQ requesters:
// round-robin accept, drive comparator inputs, wait the settle time,
// sample {w,x,y} and return it over a valid/ready response channel.
// Build option COMPS_SYNC_EN: adds a 2-flop synchronizer on w/x/y for
// pad-returned comparator outputs and extends the settle wait by 2.
module comps_seq
  import comps_seq_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int SETTLE_CYC = 2,
  parameter int CNT_W      = 16,
  parameter int ID_W       = $clog2(N_REQ)
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_ni,
  input  logic [N_REQ-1:0]          req_valid_i,
  output logic [N_REQ-1:0]          req_ready_o,
  input  logic [CMP_IN_W*N_REQ-1:0] req_data_i,
  output logic                      cmp_a_o,
  output logic                      cmp_b1_o,
  output logic                      cmp_b2_o,
  output logic                      cmp_c1_o,
  output logic                      cmp_c2_o,
  input  logic                      cmp_w_i,
  input  logic                      cmp_x_i,
  input  logic                      cmp_y_i,
  output logic                      rsp_valid_o,
  input  logic                      rsp_ready_i,
  output logic [ID_W-1:0]           rsp_id_o,
  output logic [CMP_OUT_W-1:0]      rsp_data_o,
  output logic                      busy_o,
  output logic [CNT_W-1:0]          done_cnt_o
);

`ifdef COMPS_SYNC_EN
  localparam int SETTLE_EFF = SETTLE_CYC + 2;
`else
  localparam int SETTLE_EFF = SETTLE_CYC;
`endif
  localparam int SC_W = $clog2(SETTLE_EFF) + 1;

  state_t           state_reg;
  logic [ID_W-1:0]  ptr_reg;
  logic [SC_W-1:0]  cnt_reg;
  cmp_in_t          cmp_in_reg;
  cmp_out_t         rsp_data_reg;
  logic [ID_W-1:0]  rsp_id_reg;
  logic             rsp_valid_reg;
  logic [CNT_W-1:0] done_cnt_reg;

  logic [N_REQ-1:0] grant;
  logic [ID_W-1:0]  grant_idx;
  logic             any_valid;
  cmp_out_t         cmp_out_samp;
  cmp_in_t          req_arr [N_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign req_arr[gi] = cmp_in_t'(req_data_i[CMP_IN_W*gi +: CMP_IN_W]);
    end
  endgenerate

  comps_rr_arb #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_arb (
    .req       (req_valid_i),
    .ptr       (ptr_reg),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_valid (any_valid)
  );

`ifdef COMPS_SYNC_EN
  logic [CMP_OUT_W-1:0] sync1_reg;
  logic [CMP_OUT_W-1:0] sync2_reg;

  // Two-stage synchronizer for comparator outputs coming back from pads
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= {cmp_w_i, cmp_x_i, cmp_y_i};
      sync2_reg <= sync1_reg;
    end
  end

  assign cmp_out_samp = cmp_out_t'(sync2_reg);
`else
  assign cmp_out_samp = cmp_out_t'({cmp_w_i, cmp_x_i, cmp_y_i});
`endif

  // Accept -> drive/settle -> hold response until consumed
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_reg     <= IDLE;
      ptr_reg       <= ID_W'(N_REQ - 1);
      cnt_reg       <= '0;
      cmp_in_reg    <= '0;
      rsp_data_reg  <= '0;
      rsp_id_reg    <= '0;
      rsp_valid_reg <= 1'b0;
      done_cnt_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (any_valid) begin
            cmp_in_reg <= req_arr[grant_idx];
            rsp_id_reg <= grant_idx;
            ptr_reg    <= grant_idx;
            cnt_reg    <= SC_W'(SETTLE_EFF - 1);
            state_reg  <= DRIVE;
          end
        end
        DRIVE: begin
          if (cnt_reg == '0) begin
            rsp_data_reg  <= cmp_out_samp;
            rsp_valid_reg <= 1'b1;
            state_reg     <= RESP;
          end else begin
            cnt_reg <= cnt_reg - SC_W'(1);
          end
        end
        RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_reg <= 1'b0;
            cmp_in_reg    <= '0;
            done_cnt_reg  <= done_cnt_reg + CNT_W'(1);
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Grant is only offered while arbitrating and never while reset is held
  assign req_ready_o = (state_reg == IDLE && wb_rst_ni) ? grant : '0;

  assign cmp_a_o     = cmp_in_reg.a;
  assign cmp_b1_o    = cmp_in_reg.b1;
  assign cmp_b2_o    = cmp_in_reg.b2;
  assign cmp_c1_o    = cmp_in_reg.c1;
  assign cmp_c2_o    = cmp_in_reg.c2;
  assign rsp_valid_o = rsp_valid_reg;
  assign rsp_id_o    = rsp_id_reg;
  assign rsp_data_o  = rsp_data_reg;
  assign busy_o      = (state_reg != IDLE);
  assign done_cnt_o  = done_cnt_reg;

endmodule

// File: tb/tb_comps_seq.sv
// Bench for comps_seq: a transaction-level model checked every cycle on
// the falling edge, plus directed scenarios with hand-computed values.
module tb_comps_seq;
  localparam int N  = 4;
  localparam int CW = 4;
`ifdef COMPS_SYNC_EN
  localparam int SE = 4;
`else
  localparam int SE = 2;
`endif

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [5*N-1:0] req_data;
  logic           a, b1, b2, c1, c2;
  logic           w, x, y;
  logic           rsp_valid, rsp_ready;
  logic [1:0]     rsp_id;
  logic [2:0]     rsp_data;
  logic           busy;
  logic [CW-1:0]  done_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  comps_seq #(
    .N_REQ      (N),
    .SETTLE_CYC (2),
    .CNT_W      (CW)
  ) dut (
    .wb_clk_i    (clk),
    .wb_rst_ni   (rst_n),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_data_i  (req_data),
    .cmp_a_o     (a),
    .cmp_b1_o    (b1),
    .cmp_b2_o    (b2),
    .cmp_c1_o    (c1),
    .cmp_c2_o    (c2),
    .cmp_w_i     (w),
    .cmp_x_i     (x),
    .cmp_y_i     (y),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_id_o    (rsp_id),
    .rsp_data_o  (rsp_data),
    .busy_o      (busy),
    .done_cnt_o  (done_cnt)
  );

  // Stand-in comparator
  assign w = a & b2;
  assign x = b1 | c2;
  assign y = c1;

  function automatic logic [2:0] comps_f(logic [4:0] d);
    return {d[4] & d[2], d[3] | d[0], d[1]};
  endfunction

  // Winner = valid requester at the smallest circular distance after p
  function automatic int pick(logic [N-1:0] v, int p);
    int best = -1;
    int bestd = N + 1;
    for (int j = 0; j < N; j++) begin
      int d = (j - p - 1 + N) % N;
      if (v[j] && d < bestd) begin
        best = j;
        bestd = d;
      end
    end
    return best;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Model state: one outstanding transaction at most
  bit         m_active = 0;
  int         m_t0 = 0, m_ptr = N - 1, m_id = 0, m_done = 0, cyc = 0;
  logic [4:0] m_data = '0;
  int         g_idx[$];
  int         g_cyc[$];

  always @(negedge clk) begin
    int         g;
    logic [3:0] e_ready;
    bit         e_valid;
    cyc++;
    if (!rst_n) begin
      m_active = 0;
      m_ptr    = N - 1;
      m_done   = 0;
    end
    g       = pick(req_valid, m_ptr);
    e_ready = (rst_n && !m_active && g >= 0) ? 4'(1 << g) : 4'd0;
    e_valid = m_active && (cyc - m_t0 > SE);
    chk("m_req_ready", req_ready, e_ready);
    chk("m_busy", busy, m_active);
    chk("m_cmp", {a, b1, b2, c1, c2}, m_active ? m_data : 5'd0);
    chk("m_rsp_valid", rsp_valid, e_valid);
    chk("m_done_cnt", done_cnt, m_done);
    if (e_valid) begin
      chk("m_rsp_id", rsp_id, m_id);
      chk("m_rsp_data", rsp_data, comps_f(m_data));
    end
    for (int j = 0; j < N; j++) begin
      if (req_ready[j]) begin
        g_idx.push_back(j);
        g_cyc.push_back(cyc);
      end
    end
    if (rst_n) begin
      if (!m_active) begin
        if (g >= 0) begin
          m_active = 1;
          m_t0     = cyc;
          m_id     = g;
          m_ptr    = g;
          m_data   = req_data[5*g +: 5];
        end
      end else if (e_valid && rsp_ready) begin
        m_active = 0;
        m_done   = (m_done + 1) % 16;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 50) begin
      tick();
      n++;
    end
    chk("idle_timeout", busy, 0);
  endtask

  task automatic wait_valid(output int k);
    k = 0;
    while (!rsp_valid && k < 20) begin
      tick();
      k++;
    end
    chk("valid_timeout", rsp_valid, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int n;
    // r3=11001 r2=00111 r1=10110 r0=01011
    req_data  = {5'b11001, 5'b00111, 5'b10110, 5'b01011};
    rst_n     = 1'b0;
    req_valid = 4'b1111;
    rsp_ready = 1'b0;

    // Reset state, with requests pending
    tick();
    tick();
    #1;
    chk("rst_ready", req_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_valid", rsp_valid, 0);
    chk("rst_done", done_cnt, 0);
    chk("rst_cmp", {a, b1, b2, c1, c2}, 0);
    req_valid = '0;
    rst_n = 1'b1;
    tick();
    $display("txn reset: checked");

    // All four held valid: fair order, fixed spacing
    do_reset();
    g_idx.delete();
    g_cyc.delete();
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    repeat (4 * (SE + 2) + 2) tick();
    req_valid = '0;
    wait_idle();
    chk("rr_count", (g_idx.size() >= 5), 1);
    if (g_idx.size() >= 5) begin
      chk("rr_g0", g_idx[0], 0);
      chk("rr_g1", g_idx[1], 1);
      chk("rr_g2", g_idx[2], 2);
      chk("rr_g3", g_idx[3], 3);
      chk("rr_g4", g_idx[4], 0);
      chk("rr_space", g_cyc[1] - g_cyc[0], SE + 2);
      chk("rr_space4", g_cyc[4] - g_cyc[3], SE + 2);
    end
    $display("txn round-robin: grants=%0d", g_idx.size());

    // Single request from requester 1
    do_reset();
    req_valid = 4'b0010;
    rsp_ready = 1'b1;
    #1;
    chk("single_ready", req_ready, 4'b0010);
    tick();
    req_valid = '0;
    #1;
    chk("single_ready_drop", req_ready, 0);
    wait_valid(k);
    chk("single_latency", k, SE);
    chk("single_id", rsp_id, 1);
    chk("single_data", rsp_data, 3'b101);
    tick();
    #1;
    chk("single_done", done_cnt, 1);
    chk("single_valid_drop", rsp_valid, 0);
    $display("txn single: id=%0d data=%b latency=%0d", rsp_id, rsp_data, k);

    // Backpressure on the response channel
    do_reset();
    req_valid = 4'b0001;
    rsp_ready = 1'b0;
    tick();
    req_valid = 4'b1110;
    wait_valid(k);
    for (int i = 0; i < 10; i++) begin
      tick();
      #1;
      chk("bp_valid", rsp_valid, 1);
      chk("bp_id", rsp_id, 0);
      chk("bp_data", rsp_data, 3'b011);
      chk("bp_cmp", {a, b1, b2, c1, c2}, 5'b01011);
      chk("bp_ready", req_ready, 0);
    end
    rsp_ready = 1'b1;
    tick();
    req_valid = '0;
    #1;
    chk("bp_release_valid", rsp_valid, 0);
    chk("bp_release_busy", busy, 0);
    chk("bp_release_done", done_cnt, 1);
    $display("txn backpressure: done=%0d", done_cnt);

    // Reset asserted mid-DRIVE
    do_reset();
    req_valid = 4'b0100;
    rsp_ready = 1'b1;
    tick();
    req_valid = '0;
    tick();
    rst_n = 1'b0;
    #1;
    chk("mid_busy", busy, 0);
    chk("mid_valid", rsp_valid, 0);
    chk("mid_cmp", {a, b1, b2, c1, c2}, 0);
    chk("mid_ready", req_ready, 0);
    chk("mid_rsp", {rsp_id, rsp_data}, 0);
    tick();
    tick();
    g_idx.delete();
    g_cyc.delete();
    req_valid = 4'b1111;
    rst_n = 1'b1;
    tick();
    req_valid = '0;
    chk("mid_first_count", (g_idx.size() >= 1), 1);
    if (g_idx.size() >= 1) chk("mid_first_grant", g_idx[0], 0);
    wait_idle();
    $display("txn reset-mid-drive: checked");

    // Counter wrap after 17 completions with a 4-bit counter
    do_reset();
    g_idx.delete();
    g_cyc.delete();
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    n = 0;
    while (g_idx.size() < 17 && n < 300) begin
      tick();
      n++;
    end
    req_valid = '0;
    wait_idle();
    chk("wrap_count", g_idx.size(), 17);
    chk("wrap_done", done_cnt, 1);
    $display("txn wrap: grants=%0d done=%0d", g_idx.size(), done_cnt);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
